// File: rtl/wsg_ctl_pkg.sv
// Shared constants, FSM state type and address helper for the WSG write arbiter.
package wsg_ctl_pkg;

   localparam int NUM_CH = 8;
   localparam logic [2:0] VOL_REG = 3'h3;
   localparam int WSG_AW = 6;
   localparam int WSG_DW = 8;

   typedef enum logic [1:0] {IDLE, GAP, SWEEP} wsg_state_e;

   function automatic logic [WSG_AW-1:0] vol_addr(input logic [2:0] ch);
      return {ch, VOL_REG};
   endfunction

endpackage

// File: rtl/wsg_req_fifo.sv
// Per-requester synchronous FIFO, first-word fall-through, with sticky overflow flag.
module wsg_req_fifo
   import wsg_ctl_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WSG_AW + WSG_DW
) (
   input  logic              CLK24M,
   input  logic              RST_N,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push_ok;
   logic              pop_ok;

   // Full is the registered-count view: a push against a full FIFO is lost even if a pop frees a slot this cycle.
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge CLK24M) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full) ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK24M) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wsg_wr_arbiter.sv
// Round-robin arbiter sharing the WSG register write port between two buffered requesters,
// with a MUTE-triggered volume sweep. Optional shadow readback when WSG_WR_SHADOW_EN is defined.
module wsg_wr_arbiter
   import wsg_ctl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WR_GAP     = 1
) (
   input  logic       CLK24M,
   input  logic       RST_N,
   input  logic       A_REQ,
   input  logic [5:0] A_ADDR,
   input  logic [7:0] A_DATA,
   output logic       A_FULL,
   output logic       A_OVF,
   input  logic       B_REQ,
   input  logic [5:0] B_ADDR,
   input  logic [7:0] B_DATA,
   output logic       B_FULL,
   output logic       B_OVF,
   input  logic       MUTE,
`ifdef WSG_WR_SHADOW_EN
   input  logic [5:0] RD_ADDR,
   output logic [7:0] RD_DATA,
`endif
   output logic [5:0] WSG_ADDR,
   output logic [7:0] WSG_DATA,
   output logic       WSG_WE
);

   localparam int EW    = WSG_AW + WSG_DW;
   localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(WR_GAP);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
   localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

   logic [EW-1:0]     a_dout;
   logic [EW-1:0]     b_dout;
   logic              a_empty;
   logic              b_empty;
   logic              pop_a;
   logic              pop_b;

   wsg_state_e        state;
   logic [GAP_W-1:0]  gap_cnt;
   logic [2:0]        sweep_ch;
   logic              sweep_pend;
   logic              prefer_b;
   logic              mute_q;

   logic              mute_rise;
   logic              sweep_req;
   logic              issue;
   logic              grant_b;
   logic [EW-1:0]     entry;
   logic              drop_vol;
   logic              sweep_wr;
   logic              wr_go;
   logic [WSG_AW-1:0] wr_addr;
   logic [WSG_DW-1:0] wr_data;

   wsg_req_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(EW)) u_fifo_a (
      .CLK24M (CLK24M),
      .RST_N  (RST_N),
      .push   (A_REQ),
      .din    ({A_ADDR, A_DATA}),
      .pop    (pop_a),
      .dout   (a_dout),
      .full   (A_FULL),
      .empty  (a_empty),
      .ovf    (A_OVF)
   );

   wsg_req_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(EW)) u_fifo_b (
      .CLK24M (CLK24M),
      .RST_N  (RST_N),
      .push   (B_REQ),
      .din    ({B_ADDR, B_DATA}),
      .pop    (pop_b),
      .dout   (b_dout),
      .full   (B_FULL),
      .empty  (b_empty),
      .ovf    (B_OVF)
   );

   // A pending sweep outranks queued traffic; while muted, volume writes are consumed silently.
   always_comb begin
      mute_rise = MUTE && !mute_q;
      sweep_req = mute_rise || sweep_pend;
      issue     = (state == IDLE) && !sweep_req && (!a_empty || !b_empty);
      grant_b   = !b_empty && (a_empty || prefer_b);
      pop_a     = issue && !grant_b;
      pop_b     = issue && grant_b;
      entry     = grant_b ? b_dout : a_dout;
      drop_vol  = MUTE && (entry[WSG_DW +: 3] == VOL_REG);
      sweep_wr  = ((state == IDLE) && sweep_req) || ((state == SWEEP) && (gap_cnt == '0));
      wr_go     = sweep_wr || (issue && !drop_vol);
      wr_addr   = entry[EW-1:WSG_DW];
      wr_data   = entry[WSG_DW-1:0];
      if (sweep_wr) begin
         wr_addr = vol_addr((state == IDLE) ? 3'd0 : sweep_ch);
         wr_data = '0;
      end
   end

   always_ff @(posedge CLK24M) begin
      if (!RST_N) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         sweep_ch   <= '0;
         sweep_pend <= 1'b0;
         prefer_b   <= 1'b0;
         mute_q     <= MUTE;
         WSG_WE     <= 1'b0;
         WSG_ADDR   <= '0;
         WSG_DATA   <= '0;
      end else begin
         mute_q <= MUTE;
         WSG_WE <= wr_go;
         if (wr_go) begin
            WSG_ADDR <= wr_addr;
            WSG_DATA <= wr_data;
         end
         if (mute_rise && state != SWEEP) sweep_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (sweep_req) begin
                  sweep_pend <= 1'b0;
                  sweep_ch   <= 3'd1;
                  gap_cnt    <= GAP_FULL;
                  state      <= SWEEP;
               end else if (issue) begin
                  prefer_b <= !grant_b;
                  if (!drop_vol && WR_GAP > 0) begin
                     gap_cnt <= GAP_LAST;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            SWEEP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else begin
                  sweep_ch <= sweep_ch + 1'b1;
                  gap_cnt  <= GAP_FULL;
                  if (sweep_ch == LAST_CH) begin
                     if (WR_GAP > 0) begin
                        gap_cnt <= GAP_LAST;
                        state   <= GAP;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WSG_WR_SHADOW_EN
   logic [WSG_DW-1:0] shadow [64];

   // Readback returns the pre-write value when read and write hit the same address together.
   always_ff @(posedge CLK24M) begin
      if (!RST_N) begin
         for (int i = 0; i < 64; i++) shadow[i] <= '0;
         RD_DATA <= '0;
      end else begin
         if (wr_go) shadow[wr_addr] <= wr_data;
         RD_DATA <= shadow[RD_ADDR];
      end
   end
`endif

endmodule

// File: tb/tb_wsg_wr_arbiter.sv
// Directed bench for wsg_wr_arbiter: latency, round-robin order, overflow, mute sweep, reset abort, shadow readback.
module tb_wsg_wr_arbiter;

   localparam int FIFO_DEPTH = 4;
   localparam int WR_GAP     = 1;

   logic       CLK24M = 1'b0;
   logic       RST_N;
   logic       A_REQ, B_REQ, MUTE;
   logic [5:0] A_ADDR, B_ADDR;
   logic [7:0] A_DATA, B_DATA;
   logic       A_FULL, A_OVF, B_FULL, B_OVF;
   logic [5:0] WSG_ADDR;
   logic [7:0] WSG_DATA;
   logic       WSG_WE;
`ifdef WSG_WR_SHADOW_EN
   logic [5:0] RD_ADDR;
   logic [7:0] RD_DATA;
`endif

   wsg_wr_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .WR_GAP(WR_GAP)) dut (
      .CLK24M   (CLK24M),
      .RST_N    (RST_N),
      .A_REQ    (A_REQ),
      .A_ADDR   (A_ADDR),
      .A_DATA   (A_DATA),
      .A_FULL   (A_FULL),
      .A_OVF    (A_OVF),
      .B_REQ    (B_REQ),
      .B_ADDR   (B_ADDR),
      .B_DATA   (B_DATA),
      .B_FULL   (B_FULL),
      .B_OVF    (B_OVF),
      .MUTE     (MUTE),
`ifdef WSG_WR_SHADOW_EN
      .RD_ADDR  (RD_ADDR),
      .RD_DATA  (RD_DATA),
`endif
      .WSG_ADDR (WSG_ADDR),
      .WSG_DATA (WSG_DATA),
      .WSG_WE   (WSG_WE)
   );

   always #5 CLK24M = ~CLK24M;

   typedef struct {
      logic [5:0] a;
      logic [7:0] d;
      int         c;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  vecs = 0;
   int  miss = 0;

   always @(posedge CLK24M) cyc <= cyc + 1;

   always @(negedge CLK24M) begin
      if (WSG_WE === 1'b1) wq.push_back('{a: WSG_ADDR, d: WSG_DATA, c: cyc});
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK24M);
      @(negedge CLK24M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vecs++;
      assert (obs === exp_v) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_writes(input string tag, input logic [13:0] ex[$]);
      chk({tag, "_count"}, wq.size(), ex.size());
      for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
         chk($sformatf("%s_wr%0d", tag, i), {18'd0, wq[i].a, wq[i].d}, {18'd0, ex[i]});
         if (i > 0) chk($sformatf("%s_spacing%0d", tag, i), wq[i].c - wq[i-1].c, WR_GAP + 1);
      end
   endtask

   function automatic void add_sweep(inout logic [13:0] q[$]);
      for (int ch = 0; ch < 8; ch++) q.push_back({3'(ch), 3'h3, 8'h00});
   endfunction

   logic [13:0] exq[$];
   logic [5:0]  adr_tab [5];
   logic [7:0]  dat_tab [5];
   logic        found;

   initial begin
      RST_N = 1'b0; A_REQ = 1'b0; B_REQ = 1'b0; MUTE = 1'b0;
      A_ADDR = '0; A_DATA = '0; B_ADDR = '0; B_DATA = '0;
`ifdef WSG_WR_SHADOW_EN
      RD_ADDR = '0;
`endif
      tick(); tick();
      chk("rst_we", WSG_WE, 1'b0);
      chk("rst_addr", WSG_ADDR, 6'h00);
      chk("rst_data", WSG_DATA, 8'h00);
      chk("rst_flags", {A_FULL, A_OVF, B_FULL, B_OVF}, 4'b0000);
      RST_N = 1'b1;
      tick();

      // single write latency
      A_REQ = 1'b1; A_ADDR = 6'h0B; A_DATA = 8'h5A;
      tick();
      A_REQ = 1'b0;
      chk("lat_we_t0", WSG_WE, 1'b0);
      tick();
      chk("lat_we_t1", WSG_WE, 1'b1);
      chk("lat_addr", WSG_ADDR, 6'h0B);
      chk("lat_data", WSG_DATA, 8'h5A);
      tick();
      chk("lat_we_t2", WSG_WE, 1'b0);
      chk("hold_addr", WSG_ADDR, 6'h0B);
      chk("hold_data", WSG_DATA, 8'h5A);

`ifdef WSG_WR_SHADOW_EN
      A_REQ = 1'b1; A_ADDR = 6'h25; A_DATA = 8'h33;
      tick();
      A_REQ = 1'b0;
      tick(); tick();
      RD_ADDR = 6'h25;
      tick();
      chk("shadow_hit", RD_DATA, 8'h33);
      RD_ADDR = 6'h3E;
      tick();
      chk("shadow_unwritten", RD_DATA, 8'h00);
`endif

      // round robin with both sides loaded
      RST_N = 1'b0; tick(); RST_N = 1'b1; tick();
      wq.delete();
      for (int i = 0; i < 3; i++) begin
         A_REQ = 1'b1; A_ADDR = 6'(i + 1);  A_DATA = 8'(8'h11 + i);
         B_REQ = 1'b1; B_ADDR = 6'(i + 9);  B_DATA = 8'(8'h21 + i);
         tick();
      end
      A_REQ = 1'b0; B_REQ = 1'b0;
      repeat (20) tick();
      exq.delete();
      exq.push_back({6'h01, 8'h11}); exq.push_back({6'h09, 8'h21});
      exq.push_back({6'h02, 8'h12}); exq.push_back({6'h0A, 8'h22});
      exq.push_back({6'h03, 8'h13}); exq.push_back({6'h0B, 8'h23});
      check_writes("rr", exq);

      // overflow while the sweep blocks pops
      wq.delete();
      adr_tab = '{6'h10, 6'h11, 6'h12, 6'h14, 6'h15};
      dat_tab = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      MUTE = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         A_REQ = 1'b1; A_ADDR = adr_tab[i]; A_DATA = dat_tab[i];
         tick();
      end
      A_REQ = 1'b0;
      chk("ovf_a_full", A_FULL, 1'b1);
      chk("ovf_a_ovf", A_OVF, 1'b1);
      chk("ovf_b_ovf", B_OVF, 1'b0);
      repeat (40) tick();
      exq.delete();
      add_sweep(exq);
      for (int i = 0; i < 4; i++) exq.push_back({adr_tab[i], dat_tab[i]});
      check_writes("ovf", exq);
      chk("ovf_a_full_drained", A_FULL, 1'b0);
      chk("ovf_sticky", A_OVF, 1'b1);

      // mute sweep ahead of queued B traffic, volume write discarded
      MUTE = 1'b0;
      tick(); tick();
      wq.delete();
      MUTE = 1'b1;
      B_REQ = 1'b1; B_ADDR = 6'h20; B_DATA = 8'h41;
      tick();
      B_ADDR = 6'h21; B_DATA = 8'h42;
      tick();
      B_ADDR = 6'h2B; B_DATA = 8'h7F;
      tick();
      B_REQ = 1'b0;
      repeat (40) tick();
      exq.delete();
      add_sweep(exq);
      exq.push_back({6'h20, 8'h41});
      exq.push_back({6'h21, 8'h42});
      check_writes("mute", exq);
      chk("mute_b_ovf", B_OVF, 1'b0);

      // reset in the middle of a sweep
      MUTE = 1'b0;
      tick(); tick();
      MUTE = 1'b1;
      A_REQ = 1'b1; A_ADDR = 6'h10; A_DATA = 8'h51;
      tick();
      A_ADDR = 6'h11; A_DATA = 8'h52;
      tick();
      A_REQ = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (WSG_WE === 1'b1 && WSG_ADDR === 6'h23) found = 1'b1;
         else tick();
      end
      chk("abort_reached_ch4", found, 1'b1);
      RST_N = 1'b0;
      wq.delete();
      tick();
      chk("abort_we", WSG_WE, 1'b0);
      chk("abort_addr", WSG_ADDR, 6'h00);
      chk("abort_data", WSG_DATA, 8'h00);
      chk("abort_flags", {A_FULL, A_OVF, B_FULL, B_OVF}, 4'b0000);
      RST_N = 1'b1;
      repeat (30) tick();
      chk("abort_no_writes", wq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
